snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer for the shared snooping bus between the per-processor L1 caches and main memory. It grants one cache at a time and broadcasts that cache's BusRd/BusRdX/BusUpgr/WriteBack to all other caches. It collects their hit/hitM responses, sequences any owner flush and the memory access, and returns completion plus a shared indication so the requester can pick its next MESI state.

---
 rtl/snoop_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin arbiter and transaction sequencer for the
// shared snooping bus between the per-processor L1 caches and main memory.
// Grants one cache at a time, broadcasts its command, collects hit/hitM
// responses from the other caches, sequences an owner flush and the memory
// access, then pulses completion with a shared indication.
//
// Ports:
//   clk, rst            bus clock, synchronous active-high reset
//   req_valid/cmd/addr  per-cache request, command and line address
//   grant               one-hot bus owner (held SNOOP..DONE)
//   done, done_shared   one-cycle completion pulse, line-shared flag
//   snoop_valid/cmd/addr/src  snoop broadcast to all caches
//   snoop_hit/hitm      per-cache snoop responses
//   flush_valid         owner has put its dirty line on the bus
//   mem_req/we/addr     memory access
module snoop_bus_arbiter #(
  parameter int unsigned NUM_PROCS   = 4,
  parameter int unsigned SNOOP_WAIT  = 2,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PROCS-1:0]    req_valid,
  input  logic [2*NUM_PROCS-1:0]  req_cmd,
  input  logic [32*NUM_PROCS-1:0] req_addr,
  output logic [NUM_PROCS-1:0]    grant,
  output logic [NUM_PROCS-1:0]    done,
  output logic                    done_shared,
  output logic                    snoop_valid,
  output logic [1:0]              snoop_cmd,
  output logic [31:0]             snoop_addr,
  output logic [2:0]              snoop_src,
  input  logic [NUM_PROCS-1:0]    snoop_hit,
  input  logic [NUM_PROCS-1:0]    snoop_hitm,
  input  logic                    flush_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr
);

  localparam int unsigned PID_W   = 3;
  localparam int unsigned CNT_MAX = (SNOOP_WAIT > MEM_LATENCY) ? SNOOP_WAIT : MEM_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SNOOP     = 3'd1;
  localparam logic [2:0] S_WAIT_RESP = 3'd2;
  localparam logic [2:0] S_FLUSH     = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_UPGR = 2'b10;
  localparam logic [1:0] CMD_WB   = 2'b11;

  // State and datapath registers
  logic [2:0]           r_state;
  logic [PID_W-1:0]     r_rr_ptr;
  logic [1:0]           r_cmd;
  logic [31:0]          r_addr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_hit_acc;
  logic                 r_hitm_acc;
  logic [NUM_PROCS-1:0] r_grant;
  logic [NUM_PROCS-1:0] r_done;
  logic                 r_done_shared;
  logic                 r_snoop_valid;
  logic [1:0]           r_snoop_cmd;
  logic [31:0]          r_snoop_addr;
  logic [PID_W-1:0]     r_snoop_src;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;

  // Next-state values
  logic [2:0]           w_state_nxt;
  logic [PID_W-1:0]     w_rr_ptr_nxt;
  logic [1:0]           w_cmd_nxt;
  logic [31:0]          w_addr_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_hit_acc_nxt;
  logic                 w_hitm_acc_nxt;
  logic [NUM_PROCS-1:0] w_grant_nxt;
  logic [NUM_PROCS-1:0] w_done_nxt;
  logic                 w_done_shared_nxt;
  logic                 w_snoop_valid_nxt;
  logic [1:0]           w_snoop_cmd_nxt;
  logic [31:0]          w_snoop_addr_nxt;
  logic [PID_W-1:0]     w_snoop_src_nxt;
  logic                 w_mem_req_nxt;
  logic                 w_mem_we_nxt;
  logic [31:0]          w_mem_addr_nxt;

  // Arbitration helpers
  logic                 w_hi_found;
  logic [PID_W-1:0]     w_hi_idx;
  logic                 w_lo_found;
  logic [PID_W-1:0]     w_lo_idx;
  logic [PID_W-1:0]     w_win;
  logic [1:0]           w_win_cmd;
  logic [31:0]          w_win_addr;
  logic                 w_hit_any;
  logic                 w_hitm_any;
  logic                 w_hit_fin;
  logic                 w_hitm_fin;

  // Round-robin search: lowest requester at or above rr_ptr, else lowest overall
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int j = int'(NUM_PROCS) - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PID_W'(j);
        if (PID_W'(j) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = PID_W'(j);
        end
      end
    end
  end

  assign w_win = w_hi_found ? w_hi_idx : w_lo_idx;

  // Select the winner's command and address slice
  always_comb begin
    w_win_cmd  = '0;
    w_win_addr = '0;
    for (int p = 0; p < int'(NUM_PROCS); p++) begin
      if (PID_W'(p) == w_win) begin
        w_win_cmd  = req_cmd[2*p +: 2];
        w_win_addr = req_addr[32*p +: 32];
      end
    end
  end

  // The requester's own responses never count
  assign w_hit_any  = |(snoop_hit  & ~r_grant);
  assign w_hitm_any = |(snoop_hitm & ~r_grant);
  assign w_hit_fin  = r_hit_acc  | w_hit_any;
  assign w_hitm_fin = r_hitm_acc | w_hitm_any;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_cmd_nxt         = r_cmd;
    w_addr_nxt        = r_addr;
    w_cnt_nxt         = r_cnt;
    w_hit_acc_nxt     = r_hit_acc;
    w_hitm_acc_nxt    = r_hitm_acc;
    w_grant_nxt       = r_grant;
    w_done_nxt        = '0;
    w_done_shared_nxt = 1'b0;
    w_snoop_valid_nxt = 1'b0;
    w_snoop_cmd_nxt   = r_snoop_cmd;
    w_snoop_addr_nxt  = r_snoop_addr;
    w_snoop_src_nxt   = r_snoop_src;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;

    case (r_state)
      S_IDLE: begin
        if (w_lo_found) begin
          w_state_nxt       = S_SNOOP;
          w_grant_nxt       = NUM_PROCS'(1) << w_win;
          w_cmd_nxt         = w_win_cmd;
          w_addr_nxt        = w_win_addr;
          w_rr_ptr_nxt      = (w_win == PID_W'(NUM_PROCS - 1)) ? '0 : w_win + PID_W'(1);
          w_snoop_valid_nxt = 1'b1;
          w_snoop_cmd_nxt   = w_win_cmd;
          w_snoop_addr_nxt  = w_win_addr;
          w_snoop_src_nxt   = w_win;
        end
      end

      S_SNOOP: begin
        w_state_nxt    = S_WAIT_RESP;
        w_cnt_nxt      = CNT_W'(SNOOP_WAIT);
        w_hit_acc_nxt  = 1'b0;
        w_hitm_acc_nxt = 1'b0;
      end

      // Last window cycle decides on the accumulated-plus-current responses
      S_WAIT_RESP: begin
        w_hit_acc_nxt  = w_hit_fin;
        w_hitm_acc_nxt = w_hitm_fin;
        if (r_cnt == CNT_W'(1)) begin
          if (r_cmd == CMD_WB) begin
            w_state_nxt    = S_MEM;
            w_cnt_nxt      = CNT_W'(MEM_LATENCY);
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = 1'b1;
            w_mem_addr_nxt = r_addr;
          end else if (r_cmd == CMD_UPGR) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = r_grant;
          end else if (w_hitm_fin) begin
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt    = S_MEM;
            w_cnt_nxt      = CNT_W'(MEM_LATENCY);
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = r_addr;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      // Memory absorbs the flushed dirty line
      S_FLUSH: begin
        if (flush_valid) begin
          w_state_nxt    = S_MEM;
          w_cnt_nxt      = CNT_W'(MEM_LATENCY);
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = r_addr;
        end
      end

      S_MEM: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt       = S_DONE;
          w_mem_req_nxt     = 1'b0;
          w_mem_we_nxt      = 1'b0;
          w_mem_addr_nxt    = '0;
          w_done_nxt        = r_grant;
          w_done_shared_nxt = (r_cmd == CMD_RD) & (r_hit_acc | r_hitm_acc);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_hit_acc     <= 1'b0;
      r_hitm_acc    <= 1'b0;
      r_grant       <= '0;
      r_done        <= '0;
      r_done_shared <= 1'b0;
      r_snoop_valid <= 1'b0;
      r_snoop_cmd   <= '0;
      r_snoop_addr  <= '0;
      r_snoop_src   <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_cmd         <= w_cmd_nxt;
      r_addr        <= w_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hit_acc     <= w_hit_acc_nxt;
      r_hitm_acc    <= w_hitm_acc_nxt;
      r_grant       <= w_grant_nxt;
      r_done        <= w_done_nxt;
      r_done_shared <= w_done_shared_nxt;
      r_snoop_valid <= w_snoop_valid_nxt;
      r_snoop_cmd   <= w_snoop_cmd_nxt;
      r_snoop_addr  <= w_snoop_addr_nxt;
      r_snoop_src   <= w_snoop_src_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign done_shared = r_done_shared;
  assign snoop_valid = r_snoop_valid;
  assign snoop_cmd   = r_snoop_cmd;
  assign snoop_addr  = r_snoop_addr;
  assign snoop_src   = r_snoop_src;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed-vector bench for snoop_bus_arbiter with
// hand-computed expected values, default parameters (4 caches, window 2,
// memory latency 4).
module tb_snoop_bus_arbiter;

  localparam int unsigned NP = 4;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   req_valid;
  logic [2*NP-1:0] req_cmd;
  logic [32*NP-1:0] req_addr;
  logic [NP-1:0]   grant;
  logic [NP-1:0]   done;
  logic            done_shared;
  logic            snoop_valid;
  logic [1:0]      snoop_cmd;
  logic [31:0]     snoop_addr;
  logic [2:0]      snoop_src;
  logic [NP-1:0]   snoop_hit;
  logic [NP-1:0]   snoop_hitm;
  logic            flush_valid;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;

  int n_checks;
  int n_errors;

  snoop_bus_arbiter #(
    .NUM_PROCS  (4),
    .SNOOP_WAIT (2),
    .MEM_LATENCY(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .grant      (grant),
    .done       (done),
    .done_shared(done_shared),
    .snoop_valid(snoop_valid),
    .snoop_cmd  (snoop_cmd),
    .snoop_addr (snoop_addr),
    .snoop_src  (snoop_src),
    .snoop_hit  (snoop_hit),
    .snoop_hitm (snoop_hitm),
    .flush_valid(flush_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int p, input logic [1:0] c, input logic [31:0] a);
    req_cmd[2*p +: 2]   = c;
    req_addr[32*p +: 32] = a;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = '0;
    snoop_hit   = '0;
    snoop_hitm  = '0;
    flush_valid = 1'b0;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"},       32'(grant),       32'h0);
    check({tag, ".done"},        32'(done),        32'h0);
    check({tag, ".done_shared"}, 32'(done_shared), 32'h0);
    check({tag, ".snoop_valid"}, 32'(snoop_valid), 32'h0);
    check({tag, ".snoop_cmd"},   32'(snoop_cmd),   32'h0);
    check({tag, ".snoop_addr"},  snoop_addr,       32'h0);
    check({tag, ".snoop_src"},   32'(snoop_src),   32'h0);
    check({tag, ".mem_req"},     32'(mem_req),     32'h0);
    check({tag, ".mem_we"},      32'(mem_we),      32'h0);
    check({tag, ".mem_addr"},    mem_addr,         32'h0);
  endtask

  logic [NP-1:0] exp_oh;
  logic [NP-1:0] done_seen;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_cmd     = '0;
    req_addr    = '0;
    snoop_hit   = '0;
    snoop_hitm  = '0;
    flush_valid = 1'b0;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // BusRd miss from cache 0
    set_req(0, 2'b00, 32'h984DE132);
    req_valid = 4'b0001;
    tick();                                         // cycle 1
    check("rd.grant",      32'(grant),       32'h1);
    check("rd.snoop_valid",32'(snoop_valid), 32'h1);
    check("rd.snoop_src",  32'(snoop_src),   32'h0);
    check("rd.snoop_cmd",  32'(snoop_cmd),   32'h0);
    check("rd.snoop_addr", snoop_addr,       32'h984DE132);
    tick();                                         // cycle 2
    check("rd.snoop_pulse",32'(snoop_valid), 32'h0);
    tick();                                         // cycle 3
    check("rd.mem_early",  32'(mem_req),     32'h0);
    tick();                                         // cycle 4
    check("rd.mem_req4",   32'(mem_req),     32'h1);
    check("rd.mem_we4",    32'(mem_we),      32'h0);
    check("rd.mem_addr",   mem_addr,         32'h984DE132);
    ticks(3);                                       // cycle 7
    check("rd.mem_req7",   32'(mem_req),     32'h1);
    check("rd.done7",      32'(done),        32'h0);
    tick();                                         // cycle 8
    check("rd.done",       32'(done),        32'h1);
    check("rd.shared",     32'(done_shared), 32'h0);
    check("rd.mem_off",    32'(mem_req),     32'h0);
    check("rd.grant8",     32'(grant),       32'h1);
    req_valid = '0;
    tick();                                         // cycle 9
    check("rd.done_pulse", 32'(done),        32'h0);
    check("rd.grant_drop", 32'(grant),       32'h0);

    // Four held BusUpgr requests: round-robin 0,1,2,3,0
    do_reset();
    for (int p = 0; p < 4; p++) set_req(p, 2'b10, 32'h1000_0000 + 32'(p) * 32'h40);
    req_valid = 4'b1111;
    snoop_hit = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      tick();                                       // grant cycle
      check($sformatf("rr%0d.grant", k),   32'(grant),     32'(exp_oh));
      check($sformatf("rr%0d.onehot", k),  32'($onehot0(grant)), 32'h1);
      check($sformatf("rr%0d.src", k),     32'(snoop_src), 32'(k % 4));
      ticks(3);                                     // done cycle
      check($sformatf("rr%0d.done", k),    32'(done),        32'(exp_oh));
      check($sformatf("rr%0d.shared", k),  32'(done_shared), 32'h0);
      check($sformatf("rr%0d.nomem", k),   32'(mem_req),     32'h0);
      if (k == 4) req_valid = '0;
      tick();                                       // idle gap
      check($sformatf("rr%0d.gap", k),     32'(grant),     32'h0);
    end
    snoop_hit = '0;

    // BusRd from cache 1, cache 2 owns the line Modified -> flush
    do_reset();
    set_req(1, 2'b00, 32'h116DE12F);
    req_valid = 4'b0010;
    tick();                                         // cycle 1
    check("fl.grant",     32'(grant),     32'h2);
    check("fl.src",       32'(snoop_src), 32'h1);
    tick();                                         // cycle 2
    snoop_hitm = 4'b0100;
    tick();                                         // cycle 3
    snoop_hitm = '0;
    tick();                                         // cycle 4: FLUSH
    check("fl.wait_mem",  32'(mem_req),   32'h0);
    tick();                                         // cycle 5
    check("fl.wait_mem5", 32'(mem_req),   32'h0);
    flush_valid = 1'b1;
    tick();                                         // cycle 6
    flush_valid = 1'b0;
    check("fl.mem_req6",  32'(mem_req),   32'h1);
    check("fl.mem_we6",   32'(mem_we),    32'h1);
    check("fl.mem_addr",  mem_addr,       32'h116DE12F);
    ticks(3);                                       // cycle 9
    check("fl.mem_we9",   32'(mem_we),    32'h1);
    check("fl.done9",     32'(done),      32'h0);
    tick();                                         // cycle 10
    check("fl.done",      32'(done),        32'h2);
    check("fl.shared",    32'(done_shared), 32'h1);
    check("fl.mem_off",   32'(mem_req),     32'h0);
    req_valid = '0;
    tick();

    // BusRdX from cache 0 with its own hit/hitM: masked, plain read
    do_reset();
    set_req(0, 2'b01, 32'h0ABCD040);
    req_valid  = 4'b0001;
    snoop_hit  = 4'b0001;
    snoop_hitm = 4'b0001;
    ticks(4);                                       // cycle 4
    check("own.mem_req",  32'(mem_req),     32'h1);
    check("own.mem_we",   32'(mem_we),      32'h0);
    ticks(4);                                       // cycle 8
    check("own.done",     32'(done),        32'h1);
    check("own.shared",   32'(done_shared), 32'h0);
    req_valid  = '0;
    snoop_hit  = '0;
    snoop_hitm = '0;
    tick();

    // BusRd from cache 2, cache 3 hits (clean) in the last window cycle
    do_reset();
    set_req(2, 2'b00, 32'h22222040);
    req_valid = 4'b0100;
    ticks(3);                                       // cycle 3
    snoop_hit = 4'b1000;
    tick();                                         // cycle 4
    snoop_hit = '0;
    check("sh.mem_req",   32'(mem_req),     32'h1);
    check("sh.mem_we",    32'(mem_we),      32'h0);
    ticks(4);                                       // cycle 8
    check("sh.done",      32'(done),        32'h4);
    check("sh.shared",    32'(done_shared), 32'h1);
    req_valid = '0;
    tick();

    // WriteBack from cache 3; a hitM from cache 1 must not divert it
    do_reset();
    set_req(3, 2'b11, 32'h777DE133);
    req_valid = 4'b1000;
    tick();                                         // cycle 1
    check("wb.grant",     32'(grant),     32'h8);
    check("wb.src",       32'(snoop_src), 32'h3);
    check("wb.cmd",       32'(snoop_cmd), 32'h3);
    snoop_hitm = 4'b0010;
    ticks(2);                                       // cycle 3
    snoop_hitm = '0;
    tick();                                         // cycle 4
    check("wb.mem_req",   32'(mem_req),   32'h1);
    check("wb.mem_we",    32'(mem_we),    32'h1);
    check("wb.mem_addr",  mem_addr,       32'h777DE133);
    ticks(4);                                       // cycle 8
    check("wb.done",      32'(done),        32'h8);
    check("wb.shared",    32'(done_shared), 32'h0);
    req_valid = '0;
    tick();

    // Reset during MEM abandons the transaction; cache 2 then wins from rr_ptr=0
    do_reset();
    set_req(1, 2'b00, 32'h11110000);
    req_valid = 4'b0010;
    ticks(5);                                       // cycle 5: MEM
    check("ab.mem_req",   32'(mem_req),   32'h1);
    rst       = 1'b1;
    set_req(2, 2'b00, 32'h22220080);
    req_valid = 4'b0100;
    tick();                                         // cycle 6
    rst = 1'b0;
    check_all_zero("ab");
    done_seen = '0;
    tick();                                         // cycle 7: new grant
    check("ab.grant",     32'(grant),     32'h4);
    check("ab.src",       32'(snoop_src), 32'h2);
    check("ab.addr",      snoop_addr,     32'h22220080);
    for (int i = 0; i < 6; i++) begin
      done_seen = done_seen | done;
      tick();
    end                                             // cycle 13
    done_seen = done_seen | done;
    check("ab.no_done",   32'(done_seen), 32'h0);
    tick();                                         // cycle 14
    check("ab.done",      32'(done),      32'h4);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
